// File: rtl/btn_evt_pkg.sv
// Shared types and helpers for the push-button event unit: button indices,
// the 3-bit event code and the index-to-code mapping.
package btn_evt_pkg;

  localparam int BTN_C = 0;
  localparam int BTN_U = 1;
  localparam int BTN_R = 2;
  localparam int BTN_D = 3;
  localparam int BTN_L = 4;

  typedef logic [2:0] evt_code_t;

  localparam evt_code_t EVT_NONE = 3'd0;

  // Event codes are 1-based so that 0 can mean "no event".
  function automatic evt_code_t idx_to_code(input int idx);
    return evt_code_t'(idx + 1);
  endfunction

endpackage

// File: rtl/btn_event_unit_if.sv
// CPU-side event port of btn_event_unit: head-of-queue view, pop strobe,
// occupancy and the sticky overflow flag with its clear.
interface btn_event_unit_if #(
  parameter int FIFO_DEPTH = 4
);
  import btn_evt_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // Handshake: evt_valid=1 means evt_code holds the oldest queued event;
  // evt_pop acts as ready, and the head is consumed on a rising clock edge
  // where evt_valid && evt_pop. evt_pop with evt_valid=0 has no effect.
  logic            evt_valid;
  evt_code_t       evt_code;
  logic            evt_pop;
  logic [CW-1:0]   evt_count;
  logic            evt_ovf;
  logic            ovf_clr;

  modport slave (
    output evt_valid, evt_code, evt_count, evt_ovf,
    input  evt_pop, ovf_clr
  );

  modport master (
    input  evt_valid, evt_code, evt_count, evt_ovf,
    output evt_pop, ovf_clr
  );

endinterface

// File: rtl/btn_debounce.sv
// One button: two-flop synchroniser, counter debouncer, clean level and a
// one-cycle press pulse on each debounced rising edge.
module btn_debounce #(
  parameter int DEBOUNCE_BITS = 19
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic press
);

  logic                     sync1_q, sync1_d;
  logic                     sync2_q, sync2_d;
  logic [DEBOUNCE_BITS-1:0] cnt_q, cnt_d;
  logic                     level_q, level_d;
  logic                     prev_q, prev_d;
  logic                     lock_q, lock_d;
  logic                     target;

  // After reset the debouncer behaves as if the level were high, so a button
  // held through reset must first be seen released before it can press.
  assign target = level_q | lock_q;

  always_comb begin
    sync1_d = pin;
    sync2_d = sync1_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    lock_d  = lock_q;
    prev_d  = level_q;
    if (sync2_q == target) begin
      cnt_d = '0;
    end else if (&cnt_q) begin
      level_d = sync2_q;
      lock_d  = 1'b0;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      lock_q  <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      prev_q  <= prev_d;
      lock_q  <= lock_d;
    end
  end

  assign level = level_q;
  assign press = level_q & ~prev_q;

endmodule

// File: rtl/btn_event_unit.sv
// Debounced push-buttons turned into press events queued in a small FIFO.
// Define BTN_EVT_AUTOREPEAT_EN to add autorepeat events while a button is held.
module btn_event_unit
  import btn_evt_pkg::*;
#(
  parameter int NUM_BTN       = 5,
  parameter int DEBOUNCE_BITS = 19,
  parameter int FIFO_DEPTH    = 4,
  parameter int REPEAT_BITS   = 22
) (
  input  logic               CLK100MHZ,
  input  logic               CPU_RESETN,
  input  logic [NUM_BTN-1:0] btn_in,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  btn_event_unit_if.slave    evt
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      NUM_BTN > 7 || REPEAT_BITS < 1) begin : g_param_check
    $error("btn_event_unit: unsupported parameter combination");
  end

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_BITS (DEBOUNCE_BITS)
    ) u_debounce (
      .clk   (CLK100MHZ),
      .rst_n (CPU_RESETN),
      .pin   (btn_in[g]),
      .level (btn_level[g]),
      .press (btn_press[g])
    );
  end

  logic [NUM_BTN-1:0] pend_set;

`ifdef BTN_EVT_AUTOREPEAT_EN
  logic [NUM_BTN-1:0] rep_hit;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_rep
    logic [REPEAT_BITS-1:0] rcnt_q, rcnt_d;
    logic                   rarm_q, rarm_d;
    logic                   rhit;

    // The first wrap only arms, so the first repeat lands two periods after the press.
    always_comb begin
      rcnt_d = '0;
      rarm_d = 1'b0;
      rhit   = 1'b0;
      if (btn_level[g] && !btn_press[g]) begin
        rcnt_d = rcnt_q + 1'b1;
        rarm_d = rarm_q | (&rcnt_q);
        rhit   = rarm_q & (&rcnt_q);
      end
    end

    always_ff @(posedge CLK100MHZ) begin
      if (!CPU_RESETN) begin
        rcnt_q <= '0;
        rarm_q <= 1'b0;
      end else begin
        rcnt_q <= rcnt_d;
        rarm_q <= rarm_d;
      end
    end

    assign rep_hit[g] = rhit;
  end

  assign pend_set = btn_press | rep_hit;
`else
  assign pend_set = btn_press;
`endif

  logic [NUM_BTN-1:0] pending_q, pending_d, grant;
  evt_code_t          mem_q [FIFO_DEPTH];
  evt_code_t          mem_d [FIFO_DEPTH];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               ovf_q, ovf_d, valid_q, valid_d;
  evt_code_t          code_q, code_d, push_code;
  logic               pop_ok, push_ok, drop;

  always_comb begin
    grant     = '0;
    push_code = EVT_NONE;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        grant     = '0;
        grant[i]  = 1'b1;
        push_code = idx_to_code(i);
      end
    end

    pop_ok  = evt.evt_pop && (count_q != '0);
    push_ok = (|pending_q) && ((count_q != CW'(FIFO_DEPTH)) || pop_ok);
    drop    = (|pending_q) && !push_ok;

    // A granted bit is always cleared, whether its event was queued or dropped.
    pending_d = (pending_q & ~grant) | pend_set;

    mem_d = mem_q;
    if (push_ok) mem_d[wr_ptr_q] = push_code;
    wr_ptr_d = wr_ptr_q + PW'(push_ok);
    rd_ptr_d = rd_ptr_q + PW'(pop_ok);
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);

    ovf_d = drop ? 1'b1 : (evt.ovf_clr ? 1'b0 : ovf_q);

    // Head view is computed from the next state so a push into an empty queue shows immediately.
    valid_d = (count_d != '0);
    code_d  = valid_d ? mem_d[rd_ptr_d] : EVT_NONE;
  end

  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      pending_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= EVT_NONE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      valid_q   <= 1'b0;
      code_q    <= EVT_NONE;
    end else begin
      pending_q <= pending_d;
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      valid_q   <= valid_d;
      code_q    <= code_d;
    end
  end

  assign evt.evt_valid = valid_q;
  assign evt.evt_code  = code_q;
  assign evt.evt_count = count_q;
  assign evt.evt_ovf   = ovf_q;

endmodule
